window_gen_3x3: RTL

//  Producer side of the 72-bit 3x3 pixel-window interface that the median filter consumes.

---
 rtl/window_gen_3x3.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/window_gen_3x3.sv
// window_gen_3x3
// Turns a raster-order pixel stream into one zero-padded 3x3 window per
// pixel, emitted in raster order of the window centre on a valid/ready port.
//
// state  | meaning
// -------+-------------------------------------------------------------
// FILL   | row 0 arriving; pixels go into the line buffers only
// RUN    | rows 1..H-1; each pixel with c>=1 emits window (r-1,c-1)
// EOL    | input stalled; emit the right-edge window (r-1,W-1)
// FLUSH  | input stalled; emit the bottom row windows (H-1,0..W-1)
module window_gen_3x3 #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64,
    parameter int PIX_W      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PIX_W-1:0]   pix_in,
    input  logic               pix_valid,
    output logic               pix_ready,
    output logic [9*PIX_W-1:0] win_out,
    output logic               win_valid,
    input  logic               win_ready,
    output logic               frame_done
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_EOL   = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    logic [1:0]       state;
    logic [CW-1:0]    col;
    logic [CW-1:0]    fc;
    logic [RW-1:0]    row;
    logic             active;
    logic             win_last;

    // lb1 holds row r-1, lb2 holds row r-2 relative to the incoming row
    logic [PIX_W-1:0] lb1 [IMG_WIDTH];
    logic [PIX_W-1:0] lb2 [IMG_WIDTH];

    // Columns are packed {bottom, middle, top}, top in the low bits
    logic [3*PIX_W-1:0] colp1;
    logic [3*PIX_W-1:0] colp2;
    logic [3*PIX_W-1:0] new_col;
    logic [3*PIX_W-1:0] cols [3];

    logic [CW-1:0] fc_m1;
    logic [CW-1:0] fc_p1;

    logic slot_free;
    logic accept;
    logic load;
    logic m_l, m_r, m_t, m_b;
    logic [9*PIX_W-1:0] win_next;

    assign slot_free = !win_valid || win_ready;
    // active keeps pix_ready low in the first cycle out of reset
    assign pix_ready = slot_free && active && (state == S_FILL || state == S_RUN);
    assign accept    = pix_valid && pix_ready;
    assign new_col   = {pix_in, lb1[col], lb2[col]};

    // Neighbour indices for the flush read, clamped so they stay in range
    assign fc_m1 = (fc == '0)       ? fc : fc - CW'(1);
    assign fc_p1 = (fc == COL_LAST) ? fc : fc + CW'(1);

    // Select the three source columns and the edge masks for the next window
    always_comb begin
        load    = 1'b0;
        cols[0] = '0;
        cols[1] = '0;
        cols[2] = '0;
        m_l     = 1'b0;
        m_r     = 1'b0;
        m_t     = 1'b0;
        m_b     = 1'b0;
        case (state)
            S_RUN: begin
                load    = accept && (col != '0);
                cols[0] = colp2;
                cols[1] = colp1;
                cols[2] = new_col;
                m_l     = (col == CW'(1));
                m_t     = (row == RW'(1));
            end
            S_EOL: begin
                load    = slot_free;
                cols[0] = colp2;
                cols[1] = colp1;
                m_r     = 1'b1;
                m_t     = (row == RW'(1));
            end
            S_FLUSH: begin
                load    = slot_free;
                cols[0] = {{PIX_W{1'b0}}, lb1[fc_m1], lb2[fc_m1]};
                cols[1] = {{PIX_W{1'b0}}, lb1[fc],    lb2[fc]};
                cols[2] = {{PIX_W{1'b0}}, lb1[fc_p1], lb2[fc_p1]};
                m_l     = (fc == '0);
                m_r     = (fc == COL_LAST);
                m_b     = 1'b1;
            end
            default: ;
        endcase
    end

    // Assemble the window; padding is applied by masking, so stale buffer data never leaks
    always_comb begin
        win_next = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (!((j == 0 && m_l) || (j == 2 && m_r) ||
                      (i == 0 && m_t) || (i == 2 && m_b))) begin
                    win_next[(3*i+j)*PIX_W +: PIX_W] = cols[j][i*PIX_W +: PIX_W];
                end
            end
        end
    end

    // Line buffers and the column history are pure datapath, no reset needed
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= pix_in;
            lb2[col] <= lb1[col];
            colp1    <= new_col;
            colp2    <= colp1;
        end
    end

    // Sequencer: row/col position of the input and the flush column counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_FILL;
            col    <= '0;
            row    <= '0;
            fc     <= '0;
            active <= 1'b0;
        end else begin
            active <= 1'b1;
            case (state)
                S_FILL: begin
                    if (accept) begin
                        if (col == COL_LAST) begin
                            col   <= '0;
                            row   <= RW'(1);
                            state <= S_RUN;
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (col == COL_LAST) begin
                            col   <= '0;
                            state <= S_EOL;
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                S_EOL: begin
                    if (slot_free) begin
                        if (row == ROW_LAST) begin
                            fc    <= '0;
                            state <= S_FLUSH;
                        end else begin
                            row   <= row + RW'(1);
                            state <= S_RUN;
                        end
                    end
                end
                default: begin
                    if (slot_free) begin
                        if (fc == COL_LAST) begin
                            fc    <= '0;
                            row   <= '0;
                            col   <= '0;
                            state <= S_FILL;
                        end else begin
                            fc <= fc + CW'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Output register: loads only into a free slot and holds until transferred
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_out    <= '0;
            win_valid  <= 1'b0;
            win_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= win_valid && win_ready && win_last;
            if (load) begin
                win_out   <= win_next;
                win_valid <= 1'b1;
                win_last  <= (state == S_FLUSH) && (fc == COL_LAST);
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

endmodule
